// File: rtl/turn_sequencer.sv
// Board owner for an N x N connect-WIN_LEN game: cursor, turn order and post-placement line scan.
// Optional DRAW_DETECT_EN: counts placed markers and ends a full, winless game as a draw.
module turn_sequencer #(
  parameter int N       = 5,
  parameter int WIN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mv_left,
  input  logic             mv_right,
  input  logic             mv_up,
  input  logic             mv_down,
  input  logic             place,
  input  logic             new_game,
  output logic [2*N*N-1:0] board_flat,
  output logic [2:0]       cursor_row,
  output logic [2:0]       cursor_col,
  output logic             player1_turn,
  output logic             player2_turn,
  output logic             game_finished,
  output logic             last_winner,
  output logic             draw,
  output logic             busy
);

  localparam int                CELLS     = N * N;
  localparam int                IW        = $clog2(CELLS);
  localparam logic [2:0]        MID       = 3'(N / 2);
  localparam logic [2:0]        LAST      = 3'(N - 1);
  localparam logic [2:0]        WIN_CNT   = 3'(WIN_LEN);
  localparam logic [2:0]        LAST_STEP = 3'(WIN_LEN - 1);
  localparam logic signed [3:0] N_S       = 4'(N);
  localparam logic [IW-1:0]     N_IDX     = IW'(N);

  typedef enum logic [2:0] {IDLE, SCAN_FWD, SCAN_BWD, DECIDE, OVER} state_t;

  state_t            state_q, state_d;
  logic [1:0]        board_q [CELLS];
  logic [1:0]        board_d [CELLS];
  logic [2:0]        cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [2:0]        prow_q, prow_d, pcol_q, pcol_d;
  logic [2:0]        count_q, count_d, step_q, step_d;
  logic [1:0]        dir_q, dir_d;
  logic              mover_q, mover_d, starter_q, starter_d, win_q, win_d;
  logic              finished_q, finished_d, last_winner_q, last_winner_d, draw_q, draw_d;

  logic [1:0]        mover_code;
  logic [IW-1:0]     cur_idx, scan_idx;
  logic signed [3:0] dr, dc, step_s, scan_r, scan_c;
  logic              in_bounds, hit, place_ok, board_full;
  logic [2:0]        count_inc;

  assign mover_code = mover_q ? 2'd2 : 2'd1;
  assign cur_idx    = IW'(cur_row_q) * N_IDX + IW'(cur_col_q);
  assign place_ok   = (state_q == IDLE) && place && (board_q[cur_idx] == 2'd0);
  assign count_inc  = count_q + 3'd1;

  // Cell under test: placed + step*vec, vec negated on the backward leg.
  always_comb begin
    dr = 4'sd0;
    dc = 4'sd1;
    case (dir_q)
      2'd0:    begin dr = 4'sd0; dc = 4'sd1;  end
      2'd1:    begin dr = 4'sd1; dc = 4'sd0;  end
      2'd2:    begin dr = 4'sd1; dc = 4'sd1;  end
      default: begin dr = 4'sd1; dc = -4'sd1; end
    endcase
    if (state_q == SCAN_BWD) begin
      dr = -dr;
      dc = -dc;
    end
    step_s    = $signed({1'b0, step_q});
    scan_r    = $signed({1'b0, prow_q}) + dr * step_s;
    scan_c    = $signed({1'b0, pcol_q}) + dc * step_s;
    in_bounds = (scan_r >= 4'sd0) && (scan_r < N_S) && (scan_c >= 4'sd0) && (scan_c < N_S);
    scan_idx  = IW'(scan_r[2:0]) * N_IDX + IW'(scan_c[2:0]);
    hit       = in_bounds && (board_q[scan_idx] == mover_code);
  end

`ifdef DRAW_DETECT_EN
  localparam logic [5:0] FULL_CNT = 6'(CELLS);
  logic [5:0] placed_cnt_q, placed_cnt_d;

  always_comb begin
    placed_cnt_d = placed_cnt_q;
    if (new_game)      placed_cnt_d = 6'd0;
    else if (place_ok) placed_cnt_d = placed_cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) placed_cnt_q <= 6'd0;
    else        placed_cnt_q <= placed_cnt_d;
  end

  assign board_full = (placed_cnt_q == FULL_CNT);
`else
  assign board_full = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    prow_d        = prow_q;
    pcol_d        = pcol_q;
    count_d       = count_q;
    step_d        = step_q;
    dir_d         = dir_q;
    mover_d       = mover_q;
    starter_d     = starter_q;
    win_d         = win_q;
    finished_d    = 1'b0;
    last_winner_d = last_winner_q;
    draw_d        = draw_q;
    case (state_q)
      IDLE: begin
        if (mv_left)       cur_col_d = (cur_col_q == 3'd0) ? LAST : cur_col_q - 3'd1;
        else if (mv_right) cur_col_d = (cur_col_q == LAST) ? 3'd0 : cur_col_q + 3'd1;
        else if (mv_up)    cur_row_d = (cur_row_q == 3'd0) ? LAST : cur_row_q - 3'd1;
        else if (mv_down)  cur_row_d = (cur_row_q == LAST) ? 3'd0 : cur_row_q + 3'd1;
        if (place_ok) begin
          board_d[cur_idx] = mover_code;
          prow_d  = cur_row_q;
          pcol_d  = cur_col_q;
          count_d = 3'd1;
          dir_d   = 2'd0;
          step_d  = 3'd1;
          win_d   = 1'b0;
          state_d = SCAN_FWD;
        end
      end
      SCAN_FWD, SCAN_BWD: begin
        if (hit && count_inc == WIN_CNT) begin
          count_d = count_inc;
          win_d   = 1'b1;
          state_d = DECIDE;
        end else if (hit && step_q != LAST_STEP) begin
          count_d = count_inc;
          step_d  = step_q + 3'd1;
        end else if (state_q == SCAN_FWD) begin
          // Forward run length carries into the backward leg of the same line.
          count_d = hit ? count_inc : count_q;
          step_d  = 3'd1;
          state_d = SCAN_BWD;
        end else begin
          count_d = 3'd1;
          step_d  = 3'd1;
          dir_d   = dir_q + 2'd1;
          state_d = (dir_q == 2'd3) ? DECIDE : SCAN_FWD;
        end
      end
      DECIDE: begin
        if (win_q) begin
          finished_d    = 1'b1;
          last_winner_d = mover_q;
          state_d       = OVER;
        end else if (board_full) begin
          finished_d = 1'b1;
          draw_d     = 1'b1;
          state_d    = OVER;
        end else begin
          mover_d = ~mover_q;
          state_d = IDLE;
        end
      end
      OVER:    ;
      default: state_d = IDLE;
    endcase
    if (new_game) begin
      for (int i = 0; i < CELLS; i++) board_d[i] = 2'd0;
      cur_row_d  = MID;
      cur_col_d  = MID;
      draw_d     = 1'b0;
      win_d      = 1'b0;
      finished_d = 1'b0;
      starter_d  = ~starter_q;
      mover_d    = ~starter_q;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int i = 0; i < CELLS; i++) board_q[i] <= 2'd0;
      cur_row_q     <= MID;
      cur_col_q     <= MID;
      prow_q        <= 3'd0;
      pcol_q        <= 3'd0;
      count_q       <= 3'd1;
      step_q        <= 3'd1;
      dir_q         <= 2'd0;
      mover_q       <= 1'b0;
      starter_q     <= 1'b0;
      win_q         <= 1'b0;
      finished_q    <= 1'b0;
      last_winner_q <= 1'b0;
      draw_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < CELLS; i++) board_q[i] <= board_d[i];
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      prow_q        <= prow_d;
      pcol_q        <= pcol_d;
      count_q       <= count_d;
      step_q        <= step_d;
      dir_q         <= dir_d;
      mover_q       <= mover_d;
      starter_q     <= starter_d;
      win_q         <= win_d;
      finished_q    <= finished_d;
      last_winner_q <= last_winner_d;
      draw_q        <= draw_d;
    end
  end

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_flat
    assign board_flat[2*gi +: 2] = board_q[gi];
  end

  assign cursor_row    = cur_row_q;
  assign cursor_col    = cur_col_q;
  assign busy          = (state_q == SCAN_FWD) || (state_q == SCAN_BWD) || (state_q == DECIDE);
  assign player1_turn  = (state_q != OVER) && !mover_q;
  assign player2_turn  = (state_q != OVER) && mover_q;
  assign game_finished = finished_q;
  assign last_winner   = last_winner_q;
  assign draw          = draw_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed scenarios plus random games checked
// against a board-level reference model (line lengths counted directly on a 2-D array).
module tb_turn_sequencer;
  localparam int N        = 5;
  localparam int WL       = 4;
  localparam int MAX_BUSY = 8*(WL-1) + 1;
  localparam int BUDGET   = MAX_BUSY + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mv_left = 1'b0, mv_right = 1'b0, mv_up = 1'b0, mv_down = 1'b0;
  logic place = 1'b0, new_game = 1'b0;
  logic [2*N*N-1:0] board_flat;
  logic [2:0] cursor_row, cursor_col;
  logic player1_turn, player2_turn, game_finished, last_winner, draw, busy;

  turn_sequencer #(.N(N), .WIN_LEN(WL)) dut (
    .clk(clk), .rst_n(rst_n),
    .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
    .place(place), .new_game(new_game),
    .board_flat(board_flat), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .player1_turn(player1_turn), .player2_turn(player2_turn),
    .game_finished(game_finished), .last_winner(last_winner), .draw(draw), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_board [N][N];
  int m_row, m_col, m_mover, m_starter, m_lw, m_draw, m_placed;
  bit m_over;

  // Observations from the last placement attempt
  logic [2*N*N-1:0] obs_board_first;
  int obs_busy, obs_gf, exp_gf;
  bit exp_acc;

  function automatic void model_reset(bit hard);
    if (hard) begin
      m_starter = 0;
      m_lw = 0;
    end else begin
      m_starter ^= 1;
    end
    m_mover = m_starter;
    m_over = 0; m_draw = 0; m_placed = 0;
    m_row = N/2; m_col = N/2;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m_board[r][c] = 0;
  endfunction

  function automatic bit model_wins(int r, int c, int code);
    int vr[4];
    int vc[4];
    int run, rr, cc;
    vr = '{0, 1, 1, 1};
    vc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      run = 1;
      for (int s = -1; s <= 1; s += 2) begin
        rr = r + s*vr[d];
        cc = c + s*vc[d];
        while (rr >= 0 && rr < N && cc >= 0 && cc < N && m_board[rr][cc] == code) begin
          run++;
          rr += s*vr[d];
          cc += s*vc[d];
        end
      end
      if (run >= WL) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_place(output bit acc, output int gf);
    acc = 1'b0;
    gf = 0;
    if (m_over || m_board[m_row][m_col] != 0) return;
    acc = 1'b1;
    m_board[m_row][m_col] = m_mover + 1;
    m_placed++;
    if (model_wins(m_row, m_col, m_mover + 1)) begin
      m_over = 1; m_lw = m_mover; gf = 1;
    end
`ifdef DRAW_DETECT_EN
    else if (m_placed == N*N) begin
      m_over = 1; m_draw = 1; gf = 1;
    end
`endif
    else m_mover ^= 1;
  endfunction

  function automatic logic [2*N*N-1:0] model_flat();
    logic [2*N*N-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) v[2*(r*N+c) +: 2] = 2'(m_board[r][c]);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {mv_left, mv_right, mv_up, mv_down, place, new_game} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b1);
    $display("reset");
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_reset(1'b0);
    $display("new_game: starter P%0d", m_starter + 1);
  endtask

  task automatic do_move(int d);
    @(negedge clk);
    case (d)
      0: mv_left = 1'b1;
      1: mv_right = 1'b1;
      2: mv_up = 1'b1;
      default: mv_down = 1'b1;
    endcase
    @(negedge clk);
    {mv_left, mv_right, mv_up, mv_down} = '0;
    if (!m_over) begin
      case (d)
        0: m_col = (m_col + N - 1) % N;
        1: m_col = (m_col + 1) % N;
        2: m_row = (m_row + N - 1) % N;
        default: m_row = (m_row + 1) % N;
      endcase
    end
  endtask

  task automatic goto(int r, int c);
    for (int i = 0; i < N && m_col != c; i++) do_move(1);
    for (int i = 0; i < N && m_row != r; i++) do_move(3);
  endtask

  task automatic do_place();
    int who;
    who = m_mover + 1;
    @(negedge clk); place = 1'b1;
    @(negedge clk); place = 1'b0;
    obs_board_first = board_flat;
    obs_busy = 0;
    obs_gf = game_finished ? 1 : 0;
    for (int i = 0; i < BUDGET && busy; i++) begin
      obs_busy++;
      @(negedge clk);
      if (game_finished) obs_gf++;
    end
    @(negedge clk);
    if (game_finished) obs_gf++;
    model_place(exp_acc, exp_gf);
    $display("place (%0d,%0d) by P%0d: accepted=%0d busy=%0d finished=%0d", m_row, m_col, who, exp_acc, obs_busy, obs_gf);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (board_flat !== '0) begin errors++; $display("FAIL reset_board: got %h required 0", board_flat); end
    checks++; if (cursor_row !== 3'd2 || cursor_col !== 3'd2) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (2,2)", cursor_row, cursor_col); end
    checks++; if (player1_turn !== 1'b1 || player2_turn !== 1'b0) begin errors++; $display("FAIL reset_leds: got %b%b required 10", player1_turn, player2_turn); end
    checks++; if ({game_finished, last_winner, draw, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b required 0000", {game_finished, last_winner, draw, busy}); end
  endtask

  task automatic test_cursor_wrap();
    for (int i = 0; i < 3; i++) do_move(0);
    checks++; if (cursor_row !== 3'd2 || cursor_col !== 3'd4) begin errors++; $display("FAIL cursor_wrap: got (%0d,%0d) required (2,4)", cursor_row, cursor_col); end
    checks++; if (player1_turn !== 1'b1 || board_flat !== '0) begin errors++; $display("FAIL cursor_idle: p1=%b board=%h required p1=1 board=0", player1_turn, board_flat); end
    for (int i = 0; i < 16; i++) begin
      do_move(int'($urandom_range(3)));
      checks++; if (cursor_row !== 3'(m_row) || cursor_col !== 3'(m_col)) begin errors++; $display("FAIL cursor_rand: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, m_row, m_col); end
    end
  endtask

  task automatic test_first_place();
    goto(2, 2);
    do_place();
    checks++; if (obs_board_first[2*(2*N+2) +: 2] !== 2'd1) begin errors++; $display("FAIL first_cell: got %0d required 1", obs_board_first[2*(2*N+2) +: 2]); end
    checks++; if (obs_board_first !== model_flat()) begin errors++; $display("FAIL first_board: got %h required %h", obs_board_first, model_flat()); end
    checks++; if (obs_busy !== 9) begin errors++; $display("FAIL first_latency: got %0d busy cycles required 9", obs_busy); end
    checks++; if (obs_gf !== 0) begin errors++; $display("FAIL first_finished: got %0d required 0", obs_gf); end
    checks++; if (player2_turn !== 1'b1 || player1_turn !== 1'b0) begin errors++; $display("FAIL first_turn: got %b%b required 01", player1_turn, player2_turn); end
  endtask

  task automatic test_row_win();
    int sr[7];
    int sc[7];
    logic [2*N*N-1:0] snap;
    sr = '{0, 4, 0, 3, 0, 4, 0};
    sc = '{0, 4, 1, 0, 2, 2, 3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      goto(sr[i], sc[i]);
      do_place();
      checks++; if (board_flat !== model_flat()) begin errors++; $display("FAIL row_board: got %h required %h", board_flat, model_flat()); end
      checks++; if (obs_gf !== exp_gf) begin errors++; $display("FAIL row_finished: got %0d required %0d", obs_gf, exp_gf); end
      checks++; if (obs_busy < 1 || obs_busy > MAX_BUSY) begin errors++; $display("FAIL row_latency: got %0d required 1..%0d", obs_busy, MAX_BUSY); end
    end
    checks++; if (obs_gf !== 1 || last_winner !== 1'b0) begin errors++; $display("FAIL row_win: finished=%0d winner=%b required 1,0", obs_gf, last_winner); end
    checks++; if (player1_turn !== 1'b0 || player2_turn !== 1'b0) begin errors++; $display("FAIL row_over_leds: got %b%b required 00", player1_turn, player2_turn); end
    snap = board_flat;
    do_move(1);
    checks++; if (cursor_row !== 3'(m_row) || cursor_col !== 3'(m_col)) begin errors++; $display("FAIL over_move: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, m_row, m_col); end
    do_place();
    checks++; if (obs_busy !== 0 || board_flat !== snap) begin errors++; $display("FAIL over_place: busy=%0d board=%h required 0, %h", obs_busy, board_flat, snap); end
  endtask

  task automatic test_diag_p2();
    int sr[8];
    int sc[8];
    sr = '{0, 1, 0, 3, 4, 4, 2, 2};
    sc = '{0, 3, 2, 1, 4, 0, 4, 2};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      goto(sr[i], sc[i]);
      do_place();
      checks++; if (board_flat !== model_flat() || obs_gf !== exp_gf) begin errors++; $display("FAIL diag_step: board=%h finished=%0d required %h, %0d", board_flat, obs_gf, model_flat(), exp_gf); end
    end
    checks++; if (obs_gf !== 1 || last_winner !== 1'b1) begin errors++; $display("FAIL diag_win: finished=%0d winner=%b required 1,1", obs_gf, last_winner); end
    checks++; if (obs_busy !== 11) begin errors++; $display("FAIL diag_latency: got %0d required 11", obs_busy); end
    do_new_game();
    checks++; if (last_winner !== 1'b1 || board_flat !== '0) begin errors++; $display("FAIL winner_kept: winner=%b board=%h required 1, 0", last_winner, board_flat); end
    checks++; if (player2_turn !== 1'b1 || player1_turn !== 1'b0) begin errors++; $display("FAIL starter_toggle: got %b%b required 01", player1_turn, player2_turn); end
  endtask

  task automatic test_occupied();
    do_reset();
    goto(0, 4);
    do_place();
    checks++; if (obs_busy !== 9) begin errors++; $display("FAIL corner_latency: got %0d required 9", obs_busy); end
    do_place();
    checks++; if (obs_busy !== 0 || busy !== 1'b0) begin errors++; $display("FAIL occupied_busy: got %0d required 0", obs_busy); end
    checks++; if (board_flat !== model_flat()) begin errors++; $display("FAIL occupied_board: got %h required %h", board_flat, model_flat()); end
    checks++; if (player2_turn !== 1'b1) begin errors++; $display("FAIL occupied_turn: p2=%b required 1", player2_turn); end
  endtask

  task automatic test_new_game_mid_scan();
    int gf;
    do_reset();
    goto(2, 2);
    @(negedge clk); place = 1'b1;
    @(negedge clk); place = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy: got %b required 1", busy); end
    new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_reset(1'b0);
    $display("new_game during scan");
    checks++; if (board_flat !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midscan_clear: board=%h busy=%b required 0,0", board_flat, busy); end
    checks++; if (cursor_row !== 3'd2 || cursor_col !== 3'd2) begin errors++; $display("FAIL midscan_cursor: got (%0d,%0d) required (2,2)", cursor_row, cursor_col); end
    checks++; if (player2_turn !== 1'b1 || player1_turn !== 1'b0) begin errors++; $display("FAIL midscan_turn: got %b%b required 01", player1_turn, player2_turn); end
    gf = 0;
    for (int i = 0; i < BUDGET; i++) begin
      if (game_finished) gf++;
      @(negedge clk);
    end
    checks++; if (gf !== 0) begin errors++; $display("FAIL midscan_finished: got %0d pulses required 0", gf); end
    @(negedge clk); place = 1'b1; new_game = 1'b1;
    @(negedge clk); place = 1'b0; new_game = 1'b0;
    model_reset(1'b0);
    $display("new_game with place");
    checks++; if (board_flat !== '0 || busy !== 1'b0 || player1_turn !== 1'b1) begin errors++; $display("FAIL newgame_place: board=%h busy=%b p1=%b required 0,0,1", board_flat, busy, player1_turn); end
  endtask

  task automatic test_random_games();
    int empties[$];
    int pick;
    for (int g = 0; g < 4; g++) begin
      do_new_game();
      for (int t = 0; t < N*N + 1 && !m_over; t++) begin
        empties = {};
        for (int k = 0; k < N*N; k++) if (m_board[k/N][k%N] == 0) empties.push_back(k);
        if (empties.size() == 0) break;
        pick = empties[$urandom_range(empties.size() - 1)];
        goto(pick / N, pick % N);
        do_place();
        checks++; if (board_flat !== model_flat()) begin errors++; $display("FAIL rand_board: got %h required %h", board_flat, model_flat()); end
        checks++; if (obs_gf !== exp_gf || (obs_busy > 0) !== exp_acc || obs_busy > MAX_BUSY) begin errors++; $display("FAIL rand_place: finished=%0d busy=%0d required %0d, accepted=%0d", obs_gf, obs_busy, exp_gf, exp_acc); end
        checks++; if (player1_turn !== (!m_over && m_mover == 0) || player2_turn !== (!m_over && m_mover == 1)) begin errors++; $display("FAIL rand_leds: got %b%b required mover=%0d over=%0d", player1_turn, player2_turn, m_mover, m_over); end
        checks++; if (last_winner !== 1'(m_lw) || draw !== 1'(m_draw)) begin errors++; $display("FAIL rand_result: winner=%b draw=%b required %0d,%0d", last_winner, draw, m_lw, m_draw); end
      end
    end
  endtask

  task automatic test_full_board();
    int p1[$];
    int p2[$];
    do_reset();
    for (int k = 0; k < N*N; k++) begin
      if (((k/N) % 2 == 0) ^ ((k%N) == 2 || (k%N) == 3)) p1.push_back(k);
      else p2.push_back(k);
    end
    for (int i = 0; i < N*N; i++) begin
      if (i % 2 == 0) goto(p1[i/2] / N, p1[i/2] % N);
      else goto(p2[i/2] / N, p2[i/2] % N);
      do_place();
      checks++; if (board_flat !== model_flat() || obs_gf !== exp_gf) begin errors++; $display("FAIL full_step: board=%h finished=%0d required %h, %0d", board_flat, obs_gf, model_flat(), exp_gf); end
    end
`ifdef DRAW_DETECT_EN
    checks++; if (obs_gf !== 1 || draw !== 1'b1 || last_winner !== 1'b0) begin errors++; $display("FAIL draw_end: finished=%0d draw=%b winner=%b required 1,1,0", obs_gf, draw, last_winner); end
    checks++; if (player1_turn !== 1'b0 || player2_turn !== 1'b0) begin errors++; $display("FAIL draw_leds: got %b%b required 00", player1_turn, player2_turn); end
`else
    checks++; if (obs_gf !== 0 || draw !== 1'b0) begin errors++; $display("FAIL full_nodraw: finished=%0d draw=%b required 0,0", obs_gf, draw); end
    do_place();
    checks++; if (obs_busy !== 0 || player2_turn !== 1'b1) begin errors++; $display("FAIL full_ignored: busy=%0d p2=%b required 0,1", obs_busy, player2_turn); end
`endif
    do_new_game();
    checks++; if (draw !== 1'b0 || board_flat !== '0) begin errors++; $display("FAIL full_newgame: draw=%b board=%h required 0,0", draw, board_flat); end
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_first_place();
    test_row_win();
    test_diag_p2();
    test_occupied();
    test_new_game_mid_scan();
    test_random_games();
    test_full_board();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
